// File: rtl/layer3_pkg.sv
// Shared constants and FSM state type for the layer-3 argmax stage.
package layer3_pkg;

  localparam int NODES     = 13;
  localparam int LAT       = 3;
  localparam int MAX_NODES = 13;
  localparam int DATA_W    = 8;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/layer3_argmax_cmp.sv
// Combinational compare-select: keeps the incumbent unless the candidate is strictly larger.
module argmax_cmp
  import layer3_pkg::*;
(
  input  logic [DATA_W-1:0] best,
  input  logic [IDX_W-1:0]  best_idx,
  input  logic [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]  cand_idx,
  output logic [DATA_W-1:0] new_best,
  output logic [IDX_W-1:0]  new_idx
);

  logic take;

  // Strict '>' makes ties resolve to the lower (earlier-scanned) index.
  assign take     = (cand > best);
  assign new_best = take ? cand : best;
  assign new_idx  = take ? cand_idx : best_idx;

endmodule

// File: rtl/layer3_argmax.sv
// Waits for layer-3 outputs to settle, snapshots them, then scans one node per
// cycle to find the largest activation and hands the winner out on a valid/ready port.
module layer3_argmax #(
  parameter int NODES = layer3_pkg::NODES,
  parameter int LAT   = layer3_pkg::LAT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] N0x,
  input  logic [7:0] N1x,
  input  logic [7:0] N2x,
  input  logic [7:0] N3x,
  input  logic [7:0] N4x,
  input  logic [7:0] N5x,
  input  logic [7:0] N6x,
  input  logic [7:0] N7x,
  input  logic [7:0] N8x,
  input  logic [7:0] N9x,
  input  logic [7:0] N10x,
  input  logic [7:0] N11x,
  input  logic [7:0] N12x,
  output logic [3:0] class_id,
  output logic [7:0] class_val,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       overrun
);

  import layer3_pkg::*;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] best;
  logic [IDX_W-1:0]  best_idx;
  logic [DATA_W-1:0] cmp_best;
  logic [IDX_W-1:0]  cmp_idx;
  logic [DATA_W-1:0] node_in [MAX_NODES];
  logic [DATA_W-1:0] snap    [MAX_NODES];
  logic              capture;

  assign node_in = '{N0x, N1x, N2x, N3x, N4x, N5x, N6x,
                     N7x, N8x, N9x, N10x, N11x, N12x};

  assign capture = (state == WAIT) && (cnt == '0);
  assign busy    = (state != IDLE);

  // NOTE: the snapshot is a plain data store; it is always written before it is
  // read, so it carries no reset and stays a simple register bank.
  always_ff @(posedge clk) begin
    if (capture) snap <= node_in;
  end

  argmax_cmp u_cmp (
    .best     (best),
    .best_idx (best_idx),
    .cand     (snap[idx]),
    .cand_idx (idx),
    .new_best (cmp_best),
    .new_idx  (cmp_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      best      <= '0;
      best_idx  <= '0;
      class_id  <= '0;
      class_val <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A start outside IDLE is dropped; flag it for one cycle.
      overrun <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT;
            cnt   <= CNT_W'(LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            best     <= node_in[0];
            best_idx <= '0;
            idx      <= IDX_W'(1);
            state    <= SCAN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SCAN: begin
          best     <= cmp_best;
          best_idx <= cmp_idx;
          idx      <= idx + 1'b1;
          if (idx == IDX_W'(NODES - 1)) begin
            class_id  <= cmp_idx;
            class_val <= cmp_best;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/layer3_argmax.md
LAYER3_ARGMAX -- requirements
Module: layer3_argmax

Interface
REQ-001 SHALL have parameter NODES, default 13, meaning number of layer-3 neuron outputs scanned.
REQ-002 SHALL have parameter LAT, default 3, meaning clock edges from activations presented to layer 3 until node outputs are valid.
REQ-003 SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, meaning single-cycle pulse in the same cycle the activation vector is driven onto layer-3 node A inputs.
REQ-006 SHALL have ports N0x..N12x, input, 8 each, meaning unsigned ReLU outputs of layer-3 nodes 0..12.
REQ-007 SHALL have port class_id, output, 4, meaning index of the winning node.
REQ-008 SHALL have port class_val, output, 8, meaning value of the winning node.
REQ-009 SHALL have port out_valid, output, 1, meaning class_id/class_val are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-012 SHALL have port overrun, output, 1, meaning a one-cycle pulse when start is dropped.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, SCAN, DONE.
REQ-014 SHALL, in IDLE with start=1, move to WAIT and load the wait counter with LAT-1.
REQ-015 SHALL, in WAIT, decrement the counter each edge; on the edge where the counter is 0 it SHALL snapshot N0x..N12x, set best=N0x and bestidx=0, set idx=1, and move to SCAN.
REQ-016 SHALL, if start is sampled at edge k, capture the snapshot at edge k+LAT.
REQ-017 SHALL, in SCAN, compare snap[idx] against best once per cycle and replace best/bestidx only if snap[idx] is strictly greater, so ties resolve to the lowest index.
REQ-018 SHALL, after comparing idx=NODES-1, move to DONE with out_valid=1. With defaults, out_valid rises after edge k+15.
REQ-019 SHALL hold class_id, class_val and out_valid stable in DONE until out_valid&&out_ready; on that edge it SHALL clear out_valid and return to IDLE.
REQ-020 SHALL accept start only in IDLE; start in WAIT, SCAN or DONE (including the DONE handshake cycle) SHALL be ignored and SHALL pulse overrun for one cycle.
REQ-021 SHALL, when all inputs are 0, produce class_id=0 and class_val=0.
REQ-022 SHALL treat all comparisons as 8-bit unsigned; the snapshot SHALL be immune to input changes after capture.
REQ-023 SHALL hold class_id/class_val at their previous values outside DONE; only out_valid qualifies them.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, enter IDLE and clear class_id, class_val, out_valid, overrun, best, bestidx, idx and the counter to 0, regardless of the current state.
REQ-025 SHALL give reset priority over start and out_ready in the same cycle.
REQ-026 SHALL drive busy=0 in the cycle after reset.

Structure
REQ-027 SHALL place NODES, LAT and the state enum in shared package layer3_pkg.
REQ-028 SHALL use one sub-module, argmax_cmp, a combinational compare-select taking {best, bestidx, cand, candidx} and returning the updated pair.

Verification
REQ-029 Bench SHALL check: N=[5,9,3,0,0,0,0,0,0,0,0,0,0], start at edge 0, out_ready=1 -> out_valid after edge 15 with class_id=1, class_val=9, one cycle wide.
REQ-030 Bench SHALL check: N3=N7=200, others 10 -> class_id=3, class_val=200.
REQ-031 Bench SHALL check: all N=0 -> class_id=0, class_val=0.
REQ-032 Bench SHALL check: out_ready=0 for 5 cycles in DONE, then 1 -> outputs stable for 6 cycles, then IDLE; start during the hold -> overrun pulses, no new result.
REQ-033 Bench SHALL check: N12x=255 from start until edge 3, then N inputs changed to 0 from edge 4 onward -> class_id=12, class_val=255.
REQ-034 Bench SHALL check: reset asserted mid-SCAN -> busy=0 and out_valid=0 next cycle, and a following start yields a correct fresh result.
